// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the parametrised UART TX and the future RX.
//   PARITY_*    : parity mode selectors
//   tx_state_t  : transmitter FSM state encoding
//   calc_parity : parity bit for a word that is zero-extended to 9 bits
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Zero padding does not change the XOR reduction, so one width serves every DATA_BITS.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] word,
                                       input int unsigned mode);
    logic p;
    p = ^word;
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO buffering words ahead of the UART transmitter.
//   i_Clock, i_Reset : clock, async active-high reset (empties the FIFO)
//   push, wr_data    : write strobe and word; ignored when full
//   pop, rd_data     : read strobe; rd_data shows the head word while not empty
//   full, empty      : status, decoded from the registered count
//   count            : number of words held (0..DEPTH)
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_r;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset; contents are only visible through a valid count.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: configurable UART transmitter (data width, parity, stop bits) with an
// input FIFO so frames can be sent back to back. The line idles high.
//   i_Clock, i_Reset : clock, async active-high reset (aborts any frame, empties the FIFO)
//   i_TX_DV          : write strobe; i_TX_Byte is queued when o_TX_Ready is high
//   i_TX_Byte        : payload, sent LSB first
//   o_TX_Ready       : FIFO not full
//   o_TX_Overflow    : one-cycle pulse when a write is refused because the FIFO is full
//   o_FIFO_Count     : words queued
//   o_TX_Active      : high from a start bit through the last stop bit of a burst
//   o_TX_Serial      : serial line
//   o_TX_Done        : one-cycle pulse during the final cycle of each frame
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_TX_Active,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  // Reject configurations the datapath is not built for.
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_MODE > PARITY_ODD || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo_cfg: illegal parameter combination");
  end

  tx_state_t              state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bit;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic                   frame_start_c;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .push    (i_TX_DV),
    .wr_data (i_TX_Byte),
    .pop     (frame_start_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_FIFO_Count)
  );

  assign o_TX_Ready = ~fifo_full;

  // A new frame starts from IDLE, or straight out of the last stop-bit cycle when more data waits.
  always_comb begin
    frame_start_c = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        frame_start_c = 1'b1;
      end else if (state == STOP && baud_cnt == BAUD_LAST && bit_idx == STOP_LAST) begin
        frame_start_c = 1'b1;
      end
    end
  end

  // Transmit FSM with baud counter, bit index, shift and parity registers; outputs registered.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      o_TX_Serial   <= 1'b1;
      o_TX_Active   <= 1'b0;
      o_TX_Done     <= 1'b0;
      o_TX_Overflow <= 1'b0;
    end else begin
      o_TX_Overflow <= i_TX_DV && fifo_full;
      o_TX_Done     <= 1'b0;

      unique case (state)
        IDLE: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          baud_cnt    <= '0;
          bit_idx     <= '0;
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            state       <= DATA;
            o_TX_Serial <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                state       <= PARITY;
                o_TX_Serial <= parity_bit;
              end else begin
                state       <= STOP;
                o_TX_Serial <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_idx + IDX_W'(1);
              shift_reg   <= shift_reg >> 1;
              o_TX_Serial <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            state       <= STOP;
            o_TX_Serial <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          // Raise done one edge early so it is high exactly in the frame's last cycle.
          if (baud_cnt == BAUD_PRE && bit_idx == STOP_LAST) begin
            o_TX_Done <= 1'b1;
          end
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx     <= '0;
              state       <= IDLE;
              o_TX_Active <= 1'b0;
              o_TX_Serial <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
        end
      endcase

      // Frame start overrides whatever the current state decided.
      if (frame_start_c) begin
        shift_reg   <= fifo_rd_data;
        parity_bit  <= calc_parity(MAX_DATA_BITS'(fifo_rd_data), PARITY_MODE);
        state       <= START;
        baud_cnt    <= '0;
        bit_idx     <= '0;
        o_TX_Serial <= 1'b0;
        o_TX_Active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed bench for uart_tx_fifo_cfg. Four instances cover 8N1, 8E1,
// 8O1 and 7N2; each frame is compared bit by bit against hand-built frame vectors
// (bit 0 = start, then data LSB first, parity, stop bits).
module tb_uart_tx_fifo_cfg;

  localparam int C = 217;

  logic r_Clock = 1'b0;
  logic r_Reset;

  logic [3:0]      dv;
  logic [7:0]      tx_byte0, tx_byte1, tx_byte2;
  logic [6:0]      tx_byte3;
  logic [3:0]      ser, act, done, rdy, ovf;
  logic [3:0][2:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #20 r_Clock = ~r_Clock;

  uart_tx_fifo_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .i_Clock(r_Clock), .i_Reset(r_Reset), .i_TX_DV(dv[0]), .i_TX_Byte(tx_byte0),
    .o_TX_Ready(rdy[0]), .o_TX_Overflow(ovf[0]), .o_FIFO_Count(cnt[0]),
    .o_TX_Active(act[0]), .o_TX_Serial(ser[0]), .o_TX_Done(done[0]));

  uart_tx_fifo_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .i_Clock(r_Clock), .i_Reset(r_Reset), .i_TX_DV(dv[1]), .i_TX_Byte(tx_byte1),
    .o_TX_Ready(rdy[1]), .o_TX_Overflow(ovf[1]), .o_FIFO_Count(cnt[1]),
    .o_TX_Active(act[1]), .o_TX_Serial(ser[1]), .o_TX_Done(done[1]));

  uart_tx_fifo_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .i_Clock(r_Clock), .i_Reset(r_Reset), .i_TX_DV(dv[2]), .i_TX_Byte(tx_byte2),
    .o_TX_Ready(rdy[2]), .o_TX_Overflow(ovf[2]), .o_FIFO_Count(cnt[2]),
    .o_TX_Active(act[2]), .o_TX_Serial(ser[2]), .o_TX_Done(done[2]));

  uart_tx_fifo_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .i_Clock(r_Clock), .i_Reset(r_Reset), .i_TX_DV(dv[3]), .i_TX_Byte(tx_byte3),
    .o_TX_Ready(rdy[3]), .o_TX_Overflow(ovf[3]), .o_FIFO_Count(cnt[3]),
    .o_TX_Active(act[3]), .o_TX_Serial(ser[3]), .o_TX_Done(done[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge r_Clock);
    #1;
  endtask

  task automatic set_byte(input int k, input logic [8:0] v);
    case (k)
      0: tx_byte0 = v[7:0];
      1: tx_byte1 = v[7:0];
      2: tx_byte2 = v[7:0];
      default: tx_byte3 = v[6:0];
    endcase
  endtask

  // One-cycle write strobe; returns just after the push edge.
  task automatic push1(input int k, input logic [8:0] v);
    set_byte(k, v);
    dv[k] = 1'b1;
    tick();
    dv[k] = 1'b0;
  endtask

  // Entered t0 cycles after the start edge; returns just after the frame's last cycle begins.
  // Samples first and last cycle of each bit, done position/count and active level.
  task automatic frame(input int k, input int n, input logic [15:0] expv, input string tag,
                       input int t0);
    logic [15:0] first_v, last_v, m, fm;
    int dt, dn;
    logic act_ok;
    first_v = '0; last_v = '0; dt = -1; dn = 0; act_ok = 1'b1;
    m  = 16'((32'd1 << n) - 1);
    fm = m;
    if (t0 > 0) fm[0] = 1'b0;
    for (int t = t0; t < n * C; t++) begin
      if (t % C == 0)     first_v[4'(t / C)] = ser[k];
      if (t % C == C - 1) last_v[4'(t / C)]  = ser[k];
      if (done[k]) begin dn++; dt = t; end
      if (!act[k]) act_ok = 1'b0;
      if (t < n * C - 1) tick();
    end
    check({tag, " bit_first"}, 32'(first_v & fm), 32'(expv & fm));
    check({tag, " bit_last"},  32'(last_v & m),   32'(expv & m));
    check({tag, " done_at"},   32'(dt),           32'(n * C - 1));
    check({tag, " done_n"},    32'(dn),           32'd1);
    check({tag, " active"},    32'(act_ok),       32'd1);
  endtask

  initial begin
    r_Reset = 1'b1;
    dv = '0;
    tx_byte0 = '0; tx_byte1 = '0; tx_byte2 = '0; tx_byte3 = '0;
    repeat (3) tick();

    check("rst serial",   32'(ser),    32'hF);
    check("rst active",   32'(act),    32'h0);
    check("rst done",     32'(done),   32'h0);
    check("rst overflow", 32'(ovf),    32'h0);
    check("rst ready",    32'(rdy),    32'hF);
    check("rst count",    32'(cnt[0]), 32'd0);

    r_Reset = 1'b0;
    tick();

    // 8N1, 0x3F
    push1(0, 9'h03F);
    check("t1 count", 32'(cnt[0]), 32'd1);
    check("t1 idle",  32'(ser[0]), 32'd1);
    tick();
    frame(0, 10, 16'h027E, "t1", 0);
    tick();
    check("t1 end active", 32'(act[0]), 32'd0);
    check("t1 end serial", 32'(ser[0]), 32'd1);
    check("t1 end count",  32'(cnt[0]), 32'd0);

    // Even and odd parity, 0x07
    push1(1, 9'h007);
    tick();
    frame(1, 11, 16'h060E, "t2 even", 0);
    tick();
    check("t2 even end", 32'(act[1]), 32'd0);
    push1(2, 9'h007);
    tick();
    frame(2, 11, 16'h040E, "t2 odd", 0);
    tick();
    check("t2 odd end", 32'(act[2]), 32'd0);

    // Back to back: A5, 5A, FF in consecutive cycles
    dv[0] = 1'b1;
    tx_byte0 = 8'hA5; tick();
    tx_byte0 = 8'h5A; tick();
    tx_byte0 = 8'hFF; tick();
    dv[0] = 1'b0;
    check("t3 count", 32'(cnt[0]), 32'd2);
    frame(0, 10, 16'h034A, "t3 f1", 1);
    tick();
    frame(0, 10, 16'h02B4, "t3 f2", 0);
    tick();
    frame(0, 10, 16'h03FE, "t3 f3", 0);
    tick();
    check("t3 end active", 32'(act[0]), 32'd0);

    // Overflow: six writes 0x11..0x16, the sixth is refused
    dv[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_byte0 = 8'h11 + 8'(i);
      tick();
      if (i == 4) begin
        check("t4 ready full", 32'(rdy[0]), 32'd0);
        check("t4 count full", 32'(cnt[0]), 32'd4);
        check("t4 no ovf yet", 32'(ovf[0]), 32'd0);
      end
      if (i == 5) begin
        check("t4 ovf pulse", 32'(ovf[0]), 32'd1);
        check("t4 count held", 32'(cnt[0]), 32'd4);
      end
    end
    dv[0] = 1'b0;
    tick();
    check("t4 ovf clear", 32'(ovf[0]), 32'd0);
    frame(0, 10, 16'h0222, "t4 f1", 5);
    tick();
    frame(0, 10, 16'h0224, "t4 f2", 0);
    tick();
    frame(0, 10, 16'h0226, "t4 f3", 0);
    tick();
    frame(0, 10, 16'h0228, "t4 f4", 0);
    tick();
    frame(0, 10, 16'h022A, "t4 f5", 0);
    tick();
    check("t4 end active", 32'(act[0]), 32'd0);
    check("t4 end count",  32'(cnt[0]), 32'd0);

    // 7 data bits, 2 stop bits, 0x41
    push1(3, 9'h041);
    tick();
    frame(3, 10, 16'h0382, "t5", 0);
    tick();
    check("t5 end active", 32'(act[3]), 32'd0);

    // Reset in the middle of a data bit with one word queued
    push1(0, 9'h055);
    push1(0, 9'h066);
    repeat (2 * C + 100) tick();
    check("t6 pre serial", 32'(ser[0]), 32'd0);
    check("t6 pre count",  32'(cnt[0]), 32'd1);
    #5 r_Reset = 1'b1;
    #1;
    check("t6 rst serial", 32'(ser[0]), 32'd1);
    check("t6 rst active", 32'(act[0]), 32'd0);
    check("t6 rst count",  32'(cnt[0]), 32'd0);
    tick();
    r_Reset = 1'b0;
    tick();
    push1(0, 9'h0C3);
    tick();
    frame(0, 10, 16'h0386, "t6 after", 0);
    tick();
    check("t6 end active", 32'(act[0]), 32'd0);
    check("t6 end count",  32'(cnt[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
